// File: rtl/pc_gen.sv
// ============================================================================
//  Module      : pc_gen
//  Description : Program-counter generator for the single-cycle core.
//                Registers the fetch address and picks the next address from
//                trap / stall / branch / return / jump / sequential sources.
//                An optional return-address stack (RAS) predicts returns;
//                it is compiled in when the macro PC_RAS_EN is defined.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module pc_gen #(
    parameter int              AW        = 32,
    parameter logic [AW-1:0]   RST_VEC   = '0,
    parameter int              INC       = 4,
    parameter int              RAS_DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_stall,
    input  logic          i_trap,
    input  logic [AW-1:0] i_trap_vec,
    input  logic          i_br_taken,
    input  logic [AW-1:0] i_br_target,
    input  logic          i_jmp,
    input  logic [AW-1:0] i_jmp_target,
    input  logic          i_call,
    input  logic          i_ret,
    input  logic [AW-1:0] i_ret_target,
    output logic [AW-1:0] o_pc,
    output logic [AW-1:0] o_pc_link,
    output logic          o_ras_empty,
    output logic          o_ras_full
);

    // Clears the two low address bits of every redirect target.
    localparam logic [AW-1:0] c_ALIGN = {{(AW-2){1'b1}}, 2'b00};

    logic [AW-1:0] r_pc;
    logic [AW-1:0] w_pc_link;
    logic [AW-1:0] w_ret_addr;
    logic [AW-1:0] w_next_pc;
    logic          w_advance;

    assign w_pc_link = r_pc + AW'(INC);
    assign o_pc      = r_pc;
    assign o_pc_link = w_pc_link;

    // The RAS only moves on cycles where the PC follows the program flow.
    assign w_advance = !i_trap && !i_stall && !i_br_taken;

`ifdef PC_RAS_EN
    localparam int c_PTR_W = $clog2(RAS_DEPTH);

    logic [AW-1:0]      r_ras [RAS_DEPTH];
    logic [c_PTR_W-1:0] r_wp;      // slot the next push writes
    logic [c_PTR_W:0]   r_cnt;     // valid entries, saturates at RAS_DEPTH
    logic [c_PTR_W-1:0] w_top;
    logic               w_push;
    logic               w_pop;
    logic               w_swap;

    assign w_top       = r_wp - 1'b1;
    assign o_ras_empty = (r_cnt == '0);
    assign o_ras_full  = (r_cnt == (c_PTR_W+1)'(RAS_DEPTH));
    assign w_ret_addr  = o_ras_empty ? i_ret_target : r_ras[w_top];

    assign w_swap = w_advance && i_call && i_ret;
    assign w_push = w_advance && i_call && i_jmp && !i_ret;
    assign w_pop  = w_advance && i_ret && !i_call;

    // Circular stack: a push when full overwrites the oldest slot, and a
    // call+return on an empty stack degenerates into a plain push.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < RAS_DEPTH; i++) begin
                r_ras[i] <= '0;
            end
            r_wp  <= '0;
            r_cnt <= '0;
        end else if (w_push || (w_swap && o_ras_empty)) begin
            r_ras[r_wp] <= w_pc_link;
            r_wp        <= r_wp + 1'b1;
            if (!o_ras_full) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end else if (w_swap) begin
            r_ras[w_top] <= w_pc_link;
        end else if (w_pop && !o_ras_empty) begin
            r_wp  <= w_top;
            r_cnt <= r_cnt - 1'b1;
        end
    end
`else
    logic w_unused_cfg;

    assign o_ras_empty  = 1'b1;
    assign o_ras_full   = 1'b0;
    assign w_ret_addr   = i_ret_target;
    assign w_unused_cfg = i_call ^ w_advance ^ RAS_DEPTH[0];
`endif

    // Next-PC priority: trap, stall, branch, return, jump, sequential.
    always_comb begin
        w_next_pc = w_pc_link;
        if (i_trap) begin
            w_next_pc = i_trap_vec & c_ALIGN;
        end else if (i_stall) begin
            w_next_pc = r_pc;
        end else if (i_br_taken) begin
            w_next_pc = i_br_target & c_ALIGN;
        end else if (i_ret) begin
            w_next_pc = w_ret_addr & c_ALIGN;
        end else if (i_jmp) begin
            w_next_pc = i_jmp_target & c_ALIGN;
        end
    end

    // Fetch-address register with asynchronous reset to the reset vector.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc <= RST_VEC;
        end else begin
            r_pc <= w_next_pc;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_pc_gen.sv
// ============================================================================
//  Module      : tb_pc_gen
//  Description : Self-checking bench for pc_gen; expected PC values are queued
//                when stimulus is applied and compared after the clock edge.
//                RAS scenarios run when PC_RAS_EN is defined.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_pc_gen;

    localparam int AW = 32;

    logic          clk;
    logic          rst_n;
    logic          i_stall;
    logic          i_trap;
    logic [AW-1:0] i_trap_vec;
    logic          i_br_taken;
    logic [AW-1:0] i_br_target;
    logic          i_jmp;
    logic [AW-1:0] i_jmp_target;
    logic          i_call;
    logic          i_ret;
    logic [AW-1:0] i_ret_target;
    logic [AW-1:0] o_pc;
    logic [AW-1:0] o_pc_link;
    logic          o_ras_empty;
    logic          o_ras_full;

    int            n_checks = 0;
    int            n_errors = 0;
    logic [AW-1:0] sb_q[$];

    pc_gen #(
        .AW        (AW),
        .RST_VEC   (32'h0000_0100),
        .INC       (4),
        .RAS_DEPTH (4)
    ) u_dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_stall      (i_stall),
        .i_trap       (i_trap),
        .i_trap_vec   (i_trap_vec),
        .i_br_taken   (i_br_taken),
        .i_br_target  (i_br_target),
        .i_jmp        (i_jmp),
        .i_jmp_target (i_jmp_target),
        .i_call       (i_call),
        .i_ret        (i_ret),
        .i_ret_target (i_ret_target),
        .o_pc         (o_pc),
        .o_pc_link    (o_pc_link),
        .o_ras_empty  (o_ras_empty),
        .o_ras_full   (o_ras_full)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [AW-1:0] got, input logic [AW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic clr_in();
        i_stall      = 1'b0;
        i_trap       = 1'b0;
        i_trap_vec   = '0;
        i_br_taken   = 1'b0;
        i_br_target  = '0;
        i_jmp        = 1'b0;
        i_jmp_target = '0;
        i_call       = 1'b0;
        i_ret        = 1'b0;
        i_ret_target = '0;
    endtask

    // Queue the expected PC, clock once, then compare after the edge.
    task automatic step(input string tag, input logic [AW-1:0] exp);
        sb_q.push_back(exp);
        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            chk({tag, "_sb_empty"}, 32'h1, 32'h0);
        end else begin
            chk(tag, o_pc, sb_q.pop_front());
        end
        clr_in();
    endtask

    task automatic do_jmp(input logic [AW-1:0] tgt, input logic call);
        i_jmp        = 1'b1;
        i_jmp_target = tgt;
        i_call       = call;
        step(call ? "call" : "jmp", tgt);
    endtask

    initial begin
        clr_in();
        rst_n = 1'b0;
        #12;
        chk("rst_pc", o_pc, 32'h100);
        chk("rst_link", o_pc_link, 32'h104);
        chk("rst_empty", AW'(o_ras_empty), 32'h1);
        chk("rst_full", AW'(o_ras_full), 32'h0);
        rst_n = 1'b1;

        // Free-running sequential fetch.
        for (int k = 1; k <= 3; k++) begin
            step("seq", 32'h100 + 32'(4 * k));
            chk("seq_link", o_pc_link, 32'h100 + 32'(4 * k + 4));
        end

        // Trap beats stall, branch and jump.
        i_trap = 1'b1; i_trap_vec = 32'h80; i_stall = 1'b1;
        i_br_taken = 1'b1; i_br_target = 32'h400;
        i_jmp = 1'b1; i_jmp_target = 32'h500;
        step("trap", 32'h80);
        for (int k = 0; k < 2; k++) begin
            i_stall = 1'b1; i_br_taken = 1'b1; i_br_target = 32'h600;
            step("stall", 32'h80);
        end

        // Branch target alignment and wrap of the sequential increment.
        i_br_taken = 1'b1; i_br_target = 32'h203;
        step("br_align", 32'h200);
        i_trap = 1'b1; i_trap_vec = 32'h87;
        step("trap_align", 32'h84);
        do_jmp(32'hFFFF_FFFC, 1'b0);
        chk("wrap_link", o_pc_link, 32'h0);
        step("wrap", 32'h0);

`ifdef PC_RAS_EN
        // Five calls into a four-deep stack drop the oldest link (0x14).
        do_jmp(32'h10, 1'b0);
        do_jmp(32'h20, 1'b1);
        do_jmp(32'h30, 1'b1);
        do_jmp(32'h40, 1'b1);
        do_jmp(32'h50, 1'b1);
        chk("ras_not_full4", AW'(o_ras_full), 32'h1);
        do_jmp(32'h600, 1'b1);
        chk("ras_full", AW'(o_ras_full), 32'h1);
        chk("ras_nempty", AW'(o_ras_empty), 32'h0);
        for (int k = 0; k < 4; k++) begin
            i_ret = 1'b1; i_ret_target = 32'hABC;
            step("ras_ret", 32'h54 - 32'(16 * k));
        end
        chk("ras_empty", AW'(o_ras_empty), 32'h1);
        i_ret = 1'b1; i_ret_target = 32'h700;
        step("ras_ret_fallback", 32'h700);

        // Call+return replaces the top; stall blocks it entirely.
        do_jmp(32'h1000, 1'b0);
        do_jmp(32'h300, 1'b1);
        i_stall = 1'b1; i_call = 1'b1; i_jmp = 1'b1; i_ret = 1'b1;
        i_jmp_target = 32'h900; i_ret_target = 32'hBBC;
        step("swap_stall", 32'h300);
        i_call = 1'b1; i_jmp = 1'b1; i_ret = 1'b1;
        i_jmp_target = 32'h900; i_ret_target = 32'hBBC;
        step("swap", 32'h1004);
        chk("swap_nempty", AW'(o_ras_empty), 32'h0);
        i_ret = 1'b1; i_ret_target = 32'hCC0;
        step("swap_top", 32'h304);
        chk("swap_cnt1", AW'(o_ras_empty), 32'h1);
`else
        // Without the RAS, calls are ignored and returns use ret_target.
        do_jmp(32'h40, 1'b1);
        chk("noras_empty_call", AW'(o_ras_empty), 32'h1);
        chk("noras_full", AW'(o_ras_full), 32'h0);
        i_ret = 1'b1; i_ret_target = 32'h500;
        step("noras_ret", 32'h500);
        chk("noras_empty_ret", AW'(o_ras_empty), 32'h1);
`endif

        // Asynchronous reset mid-operation, checked between clock edges.
        step("pre_rst", o_pc + 32'h4);
        rst_n = 1'b0;
        #2;
        chk("async_rst_pc", o_pc, 32'h100);
        chk("async_rst_empty", AW'(o_ras_empty), 32'h1);
        @(negedge clk);
        rst_n = 1'b1;
        step("post_rst", 32'h104);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
